ml_cache_ctrl: RTL and testbench

ML_CACHE_CTRL -- requirements
Module: ml_cache_ctrl

---
 rtl/ml_cache_pkg.sv | 22 ++
 rtl/ml_cache_level.sv | 51 +++++
 rtl/ml_cache_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ml_cache_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_cache_pkg.sv
// ml_cache_pkg: FSM encoding and statistics counter sizing
// shared by the ml_cache_ctrl files.
package ml_cache_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_L2_FILL,
    S_MEM_RD,
    S_MEM_WR,
    S_RESP
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ml_cache_level.sv
// ml_cache_level: one direct-mapped tag/data/valid array.
// Lookup is combinational; write-on-hit, fill and flush are clocked.
module ml_cache_level
  import ml_cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;

  assign w_idx   = i_addr[IDX_W-1:0];
  assign w_tag   = i_addr[ADDR_W-1:IDX_W];
  assign o_hit   = r_valid[w_idx] &&
                   (r_tag[w_idx] == w_tag);
  assign o_rdata = r_data[w_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_valid        <= '0;
    else if (i_flush) r_valid        <= '0;
    else if (i_fill)  r_valid[w_idx] <= 1'b1;
  end

  // Tag/data carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (i_fill)
      r_tag[w_idx] <= w_tag;
    if (i_fill || (i_wr && o_hit))
      r_data[w_idx] <= i_wdata;
  end

endmodule

// File: rtl/ml_cache_ctrl.sv
// ml_cache_ctrl: two-level write-through direct-mapped cache.
// Define ML_CACHE_STATS_EN to build the hit/miss counters.
module ml_cache_ctrl
  import ml_cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int L1_LINES = 16,
  parameter int L2_LINES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              hit1,
  output logic              hit2,
  output logic              busy,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  l1_hit_cnt,
  output logic [CNT_W-1:0]  l2_hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_t r_state, w_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hit1;
  logic              r_hit2;

  logic              w_hit1, w_hit2;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic              w_accept, w_flush;
  logic              w_l1_wr, w_l1_fill;
  logic              w_l2_wr, w_l2_fill;
  logic [DATA_W-1:0] w_l1_wd, w_l2_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    w_accept  = 1'b0;
    w_flush   = 1'b0;
    w_l1_wr   = 1'b0;
    w_l2_wr   = 1'b0;
    w_l1_fill = 1'b0;
    w_l2_fill = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = !flush;
        w_flush   = flush;
        w_accept  = req_valid && !flush;
        if (w_accept) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (r_we) begin
          w_l1_wr = 1'b1;
          w_l2_wr = 1'b1;
          w_next  = S_MEM_WR;
        end
        else if (w_hit1) w_next = S_RESP;
        else if (w_hit2) w_next = S_L2_FILL;
        else             w_next = S_MEM_RD;
      end
      S_L2_FILL: begin
        w_l1_fill = 1'b1;
        w_next    = S_RESP;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_l1_fill = 1'b1;
          w_l2_fill = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit1  <= 1'b0;
      r_hit2  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_LOOKUP) begin
        r_hit1  <= w_hit1;
        r_hit2  <= w_hit2 && !w_hit1;
        r_rdata <= r_we   ? '0    :
                   w_hit1 ? w_rd1 : w_rd2;
      end
      if (r_state == S_MEM_RD && mem_ack)
        r_rdata <= mem_rdata;
    end
  end

  // L1 refills from memory or from the L2 copy held in r_rdata.
  assign w_l1_wd = (r_state == S_MEM_RD)  ? mem_rdata :
                   (r_state == S_L2_FILL) ? r_rdata   :
                                            r_wdata;
  assign w_l2_wd = (r_state == S_MEM_RD)  ? mem_rdata :
                                            r_wdata;

  ml_cache_level #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (L1_LINES)
  ) u_l1 (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_addr  (r_addr),
    .i_wr    (w_l1_wr),
    .i_fill  (w_l1_fill),
    .i_wdata (w_l1_wd),
    .o_hit   (w_hit1),
    .o_rdata (w_rd1)
  );

  ml_cache_level #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LINES  (L2_LINES)
  ) u_l2 (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_addr  (r_addr),
    .i_wr    (w_l2_wr),
    .i_fill  (w_l2_fill),
    .i_wdata (w_l2_wd),
    .o_hit   (w_hit2),
    .o_rdata (w_rd2)
  );

  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign hit1      = rsp_valid && r_hit1;
  assign hit2      = rsp_valid && r_hit2;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

`ifdef ML_CACHE_STATS_EN
  logic [CNT_W-1:0] r_l1_cnt;
  logic [CNT_W-1:0] r_l2_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l1_cnt   <= '0;
      r_l2_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_RESP) begin
      if (r_hit1)      r_l1_cnt   <= sat_inc(r_l1_cnt);
      else if (r_hit2) r_l2_cnt   <= sat_inc(r_l2_cnt);
      else             r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign l1_hit_cnt = r_l1_cnt;
  assign l2_hit_cnt = r_l2_cnt;
  assign miss_cnt   = r_miss_cnt;
`else
  assign l1_hit_cnt = '0;
  assign l2_hit_cnt = '0;
  assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_ml_cache_ctrl.sv
// tb_ml_cache_ctrl: directed and randomized checks of ml_cache_ctrl
// against an address-level cache model and a memory responder.
module tb_ml_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        hit1, hit2, busy;
  logic        flush = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] l1_hit_cnt, l2_hit_cnt, miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ml_cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .hit1       (hit1),
    .hit2       (hit2),
    .busy       (busy),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .l1_hit_cnt (l1_hit_cnt),
    .l2_hit_cnt (l2_hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  // Model: each line remembers the full address it caches.
  bit          m1_v [16];
  logic [31:0] m1_a [16];
  logic [7:0]  m1_d [16];
  bit          m2_v [64];
  logic [31:0] m2_a [64];
  logic [7:0]  m2_d [64];
  logic [7:0]  mem [logic [31:0]];
  int e_l1 = 0, e_l2 = 0, e_miss = 0;

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m1_v[i] = 1'b0;
    for (int i = 0; i < 64; i++) m2_v[i] = 1'b0;
  endtask

  task automatic model_access(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [7:0]  wd,
    output logic [7:0]  rd,
    output logic        h1,
    output logic        h2,
    output int          nmem
  );
    int i1 = int'(a % 16);
    int i2 = int'(a % 64);
    bit in1 = m1_v[i1] && (m1_a[i1] == a);
    bit in2 = m2_v[i2] && (m2_a[i2] == a);
    rd = '0; h1 = 1'b0; h2 = 1'b0; nmem = 0;
    if (we) begin
      h1 = in1;
      h2 = in2 && !in1;
      if (in1) m1_d[i1] = wd;
      if (in2) m2_d[i2] = wd;
      mem[a] = wd;
      nmem = 1;
    end else if (in1) begin
      h1 = 1'b1;
      rd = m1_d[i1];
    end else if (in2) begin
      h2 = 1'b1;
      rd = m2_d[i2];
      m1_v[i1] = 1'b1; m1_a[i1] = a; m1_d[i1] = rd;
    end else begin
      rd = mem_val(a);
      nmem = 1;
      m1_v[i1] = 1'b1; m1_a[i1] = a; m1_d[i1] = rd;
      m2_v[i2] = 1'b1; m2_a[i2] = a; m2_d[i2] = rd;
    end
    if (h1)      e_l1++;
    else if (h2) e_l2++;
    else         e_miss++;
  endtask

  // Drives one request, plays memory, reports what the DUT did.
  task automatic run_req(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [7:0]  wd,
    output logic [7:0]  rd,
    output logic        h1,
    output logic        h2,
    output int          nmem,
    output int          lat,
    output bit          bad_mem,
    output bit          pulse_ok,
    output bit          to
  );
    int dly = 0;
    bit pend = 0;
    rd = '0; h1 = 1'b0; h2 = 1'b0; nmem = 0; lat = 0;
    bad_mem = 0; pulse_ok = 0; to = 1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we;
    req_addr = a; req_wdata = wd;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    req_addr = $urandom; req_wdata = 8'($urandom);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      lat++;
      mem_ack = 1'b0;
      if (rsp_valid) begin
        rd = rsp_rdata; h1 = hit1; h2 = hit2; to = 0;
        break;
      end
      if (mem_req) begin
        if (!pend) begin
          pend = 1; nmem++; dly = $urandom_range(0, 3);
        end
        if (mem_we !== we || mem_addr !== a ||
            (we && mem_wdata !== wd)) bad_mem = 1;
        if (dly == 0) begin
          mem_ack = 1'b1;
          mem_rdata = (!we && mem.exists(a)) ? mem[a]
                                             : 8'($urandom);
          pend = 0;
        end else dly--;
      end
    end
    @(negedge clk);
    pulse_ok = (rsp_valid === 1'b0) && (busy === 1'b0);
  endtask

  task automatic do_flush(output bit rdy, output bit bsy);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    req_we = 1'b0; req_addr = 32'h40;
    #1 rdy = req_ready;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    bsy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: busy=%b mem_req=%b rsp_valid=%b, want 0 0 0",
               busy, mem_req, rsp_valid);
    end
    n_tests++;
    if (rsp_rdata !== 8'h00 || hit1 !== 1'b0 || hit2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: rdata=%h hit1=%b hit2=%b, want 00 0 0",
               rsp_rdata, hit1, hit2);
    end
    n_tests++;
    if (l1_hit_cnt !== 16'd0 || l2_hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: %0d %0d %0d, want 0 0 0",
               l1_hit_cnt, l2_hit_cnt, miss_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: req_ready=%b busy=%b, want 1 0",
               req_ready, busy);
    end
  endtask

  task automatic test_directed();
    logic [7:0] rd, erd;
    logic h1, h2, eh1, eh2;
    int nm, enm, lat;
    bit bm, po, to;
    mem[32'h40] = 8'hA5;
    mem[32'h50] = 8'h5A;

    model_access(1'b0, 32'h40, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h40, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || bm || !po || rd !== 8'hA5 || h1 !== 1'b0 ||
        h2 !== 1'b0 || nm !== 1) begin
      n_fail++;
      $display("FAIL cold_read: rd=%h h1=%b h2=%b nmem=%0d to=%b bm=%b po=%b, want a5 0 0 1",
               rd, h1, h2, nm, to, bm, po);
    end

    model_access(1'b0, 32'h40, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h40, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== 8'hA5 || h1 !== 1'b1 || h2 !== 1'b0 || nm !== 0) begin
      n_fail++;
      $display("FAIL l1_hit: rd=%h h1=%b h2=%b nmem=%0d, want a5 1 0 0",
               rd, h1, h2, nm);
    end
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL l1_latency: got %0d cycles, want 2", lat);
    end

    model_access(1'b0, 32'h50, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h50, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== 8'h5A || h1 !== 1'b0 || h2 !== 1'b0 || nm !== 1) begin
      n_fail++;
      $display("FAIL conflict_read: rd=%h h1=%b h2=%b nmem=%0d, want 5a 0 0 1",
               rd, h1, h2, nm);
    end

    model_access(1'b0, 32'h40, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h40, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== 8'hA5 || h1 !== 1'b0 || h2 !== 1'b1 ||
        nm !== 0 || lat !== 3) begin
      n_fail++;
      $display("FAIL l2_hit: rd=%h h1=%b h2=%b nmem=%0d lat=%0d, want a5 0 1 0 3",
               rd, h1, h2, nm, lat);
    end

    model_access(1'b1, 32'h40, 8'h3C, erd, eh1, eh2, enm);
    run_req(1'b1, 32'h40, 8'h3C, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || bm || rd !== 8'h00 || h1 !== 1'b1 || h2 !== 1'b0 || nm !== 1) begin
      n_fail++;
      $display("FAIL write_hit: rd=%h h1=%b h2=%b nmem=%0d bm=%b, want 00 1 0 1 0",
               rd, h1, h2, nm, bm);
    end

    model_access(1'b0, 32'h40, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h40, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== 8'h3C || h1 !== 1'b1 || nm !== 0) begin
      n_fail++;
      $display("FAIL read_after_write: rd=%h h1=%b nmem=%0d, want 3c 1 0",
               rd, h1, nm);
    end
  endtask

  task automatic test_flush();
    logic [7:0] rd, erd;
    logic h1, h2, eh1, eh2;
    int nm, enm, lat;
    bit bm, po, to, rdy, bsy;
    do_flush(rdy, bsy);
    model_flush();
    n_tests++;
    if (rdy !== 1'b0 || bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_block: req_ready=%b busy=%b, want 0 0", rdy, bsy);
    end
    model_access(1'b0, 32'h40, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, 32'h40, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== erd || h1 !== 1'b0 || h2 !== 1'b0 || nm !== 1) begin
      n_fail++;
      $display("FAIL after_flush: rd=%h h1=%b h2=%b nmem=%0d, want %h 0 0 1",
               rd, h1, h2, nm, erd);
    end
  endtask

  task automatic test_idle_ack();
    bit seen = 0;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    repeat (2) begin
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || mem_req !== 1'b0) seen = 1;
    end
    mem_ack = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL idle_ack: DUT reacted to stray mem_ack, want no activity");
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0] wd, rd, erd;
    logic we, h1, h2, eh1, eh2;
    int nm, enm, lat, elat;
    bit bm, po, to, rdy, bsy;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_flush(rdy, bsy);
        model_flush();
        n_tests++;
        if (rdy !== 1'b0 || bsy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_flush[%0d]: req_ready=%b busy=%b, want 0 0",
                   i, rdy, bsy);
        end
      end
      we = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 3) << 28) | $urandom_range(0, 127);
      wd = 8'($urandom);
      model_access(we, a, wd, erd, eh1, eh2, enm);
      run_req(we, a, wd, rd, h1, h2, nm, lat, bm, po, to);
      elat = (!we && eh1) ? 2 : ((!we && eh2) ? 3 : lat);
      n_tests++;
      if (to || bm || !po || rd !== erd || h1 !== eh1 ||
          h2 !== eh2 || nm !== enm || lat !== elat) begin
        n_fail++;
        $display("FAIL rand[%0d] we=%b a=%h: rd=%h h1=%b h2=%b nmem=%0d lat=%0d to=%b bm=%b po=%b, want rd=%h h1=%b h2=%b nmem=%0d lat=%0d",
                 i, we, a, rd, h1, h2, nm, lat, to, bm, po,
                 erd, eh1, eh2, enm, elat);
      end
    end
  endtask

  task automatic test_counters();
    int x1, x2, xm;
`ifdef ML_CACHE_STATS_EN
    x1 = e_l1; x2 = e_l2; xm = e_miss;
`else
    x1 = 0; x2 = 0; xm = 0;
`endif
    n_tests++;
    if (l1_hit_cnt !== 16'(x1)) begin
      n_fail++;
      $display("FAIL cnt_l1: got %0d, want %0d", l1_hit_cnt, x1);
    end
    n_tests++;
    if (l2_hit_cnt !== 16'(x2)) begin
      n_fail++;
      $display("FAIL cnt_l2: got %0d, want %0d", l2_hit_cnt, x2);
    end
    n_tests++;
    if (miss_cnt !== 16'(xm)) begin
      n_fail++;
      $display("FAIL cnt_miss: got %0d, want %0d", miss_cnt, xm);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = 32'h1234_5677;
    logic [7:0] rd, erd;
    logic h1, h2, eh1, eh2;
    int nm, enm, lat;
    bit bm, po, to, rsp_seen;
    do_flush(po, bm);
    model_flush();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach_memrd: mem_req=%b, want 1", mem_req);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: mem_req=%b busy=%b rsp_valid=%b, want 0 0 0",
               mem_req, busy, rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_flush();
    e_l1 = 0; e_l2 = 0; e_miss = 0;
    rsp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) rsp_seen = 1;
    end
    n_tests++;
    if (rsp_seen) begin
      n_fail++;
      $display("FAIL mid_dropped: response or busy seen after reset, want none");
    end
    n_tests++;
    if (l1_hit_cnt !== 16'd0 || l2_hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_cnt: %0d %0d %0d, want 0 0 0",
               l1_hit_cnt, l2_hit_cnt, miss_cnt);
    end
    model_access(1'b0, a, 8'h0, erd, eh1, eh2, enm);
    run_req(1'b0, a, 8'h0, rd, h1, h2, nm, lat, bm, po, to);
    n_tests++;
    if (to || rd !== erd || h1 !== 1'b0 || h2 !== 1'b0 || nm !== 1) begin
      n_fail++;
      $display("FAIL mid_recover: rd=%h h1=%b h2=%b nmem=%0d, want %h 0 0 1",
               rd, h1, h2, nm, erd);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_idle_ack();
    test_random();
    test_counters();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
